// File: rtl/crop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crop_pkg
//  Description : Shared types and helpers for the crop window stage and the
//                raster counter. Holds the config FSM encoding, the shadow
//                crop-rectangle record and the counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package crop_pkg;

    // Shadow config fields are stored at a fixed width so the record type
    // does not depend on the frame geometry of any one instance. Ports are
    // zero-extended into it; frame dimensions must fit in this width.
    localparam int c_cfg_field_w = 16;

    // Config FSM: one LOAD cycle per frame, RUN for the pixels themselves.
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } crop_state_t;

    // Crop rectangle as latched at the start of a frame.
    typedef struct packed {
        logic [c_cfg_field_w-1:0] x0;
        logic [c_cfg_field_w-1:0] y0;
        logic [c_cfg_field_w-1:0] w;
        logic [c_cfg_field_w-1:0] h;
    } cfg_t;

    // Bits needed to hold every value 0..n inclusive (a coordinate or an
    // extent such as a width equal to the full frame).
    function automatic int width_for(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : raster_counter
//  Description : Column/row position tracker for a raster-scan frame. Steps
//                once per accepted pixel, wraps the column at the end of a
//                line and both coordinates at the end of the frame.
//  Ports       : clk, reset          - clock, async active-high reset
//                advance             - one pixel consumed this cycle
//                col, row            - position of the pixel being offered
//                end_of_frame        - current position is the last pixel
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_counter
    import crop_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 6,
    parameter int XW         = width_for(IMG_WIDTH),
    parameter int YW         = width_for(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [XW-1:0] col,
    output logic [YW-1:0] row,
    output logic          end_of_frame
);

    localparam logic [XW-1:0] c_col_last = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] c_row_last = YW'(IMG_HEIGHT - 1);

    logic [XW-1:0] r_col;
    logic [YW-1:0] r_row;
    logic          w_col_wrap;
    logic          w_row_wrap;

    assign w_col_wrap = (r_col == c_col_last);
    assign w_row_wrap = (r_row == c_row_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (advance) begin
            if (w_col_wrap) begin
                r_col <= '0;
                // Last pixel of the last line: restart the frame.
                if (w_row_wrap) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + YW'(1);
                end
            end else begin
                r_col <= r_col + XW'(1);
            end
        end
    end

    assign col          = r_col;
    assign row          = r_row;
    assign end_of_frame = w_col_wrap && w_row_wrap;

endmodule
`default_nettype wire

// File: rtl/crop_window_stage.sv
`default_nettype none
// ============================================================================
//  Module      : crop_window_stage
//  Description : Raster-scan pixel cropper feeding a first-word-fall-through
//                FIFO. Consumes a full IMG_WIDTH x IMG_HEIGHT frame, forwards
//                only the pixels inside a per-frame crop rectangle through a
//                single output register and flags the last cropped pixel.
//  Ports       : clk, reset                 - clock, async active-high reset
//                cfg_x0/cfg_y0/cfg_w/cfg_h  - crop rectangle, sampled once
//                                             per frame in the LOAD cycle
//                in_data/in_valid/in_ready  - full-frame pixel stream
//                out_data/out_valid/out_ready/out_last
//                                           - cropped pixel stream
//                frame_done                 - pulse after end-of-frame accept
//                cfg_err                    - current frame's config invalid
//  Revision    : 1.0 - initial release
// ============================================================================
module crop_window_stage
    import crop_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 6,
    parameter int XW         = width_for(IMG_WIDTH),
    parameter int YW         = width_for(IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XW-1:0]         cfg_x0,
    input  logic [YW-1:0]         cfg_y0,
    input  logic [XW-1:0]         cfg_w,
    input  logic [YW-1:0]         cfg_h,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  cfg_err
);

    // Window arithmetic runs one bit wider than the stored fields so that
    // x0+w and y0+h can never wrap.
    localparam int c_cw = c_cfg_field_w + 1;

    localparam logic [XW:0] c_img_w = (XW + 1)'(IMG_WIDTH);
    localparam logic [YW:0] c_img_h = (YW + 1)'(IMG_HEIGHT);

    // ------------------------------------------------------------------
    // Raster position
    // ------------------------------------------------------------------
    logic [XW-1:0] w_col;
    logic [YW-1:0] w_row;
    logic          w_eof;
    logic          w_accept;

    raster_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .XW         (XW),
        .YW         (YW)
    ) u_raster (
        .clk          (clk),
        .reset        (reset),
        .advance      (w_accept),
        .col          (w_col),
        .row          (w_row),
        .end_of_frame (w_eof)
    );

    // ------------------------------------------------------------------
    // Config capture and validation
    // ------------------------------------------------------------------
    crop_state_t r_state;
    cfg_t        r_cfg;
    cfg_t        w_cfg_in;
    logic        r_cfg_err;
    logic        w_cfg_err_in;
    logic        r_frame_done;
    logic [XW:0] w_cfg_x_end;
    logic [YW:0] w_cfg_y_end;

    always_comb begin
        w_cfg_in               = '0;
        w_cfg_in.x0[XW-1:0]    = cfg_x0;
        w_cfg_in.y0[YW-1:0]    = cfg_y0;
        w_cfg_in.w[XW-1:0]     = cfg_w;
        w_cfg_in.h[YW-1:0]     = cfg_h;
    end

    assign w_cfg_x_end  = {1'b0, cfg_x0} + {1'b0, cfg_w};
    assign w_cfg_y_end  = {1'b0, cfg_y0} + {1'b0, cfg_h};

    // An empty or out-of-frame rectangle makes the whole frame a drop frame.
    assign w_cfg_err_in = (cfg_w == '0) || (cfg_h == '0) ||
                          (w_cfg_x_end > c_img_w) || (w_cfg_y_end > c_img_h);

    // LOAD lasts exactly one cycle: it is where the next frame's rectangle is
    // latched, and it doubles as the frame_done cycle of the previous frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_LOAD;
            r_cfg        <= '0;
            r_cfg_err    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    r_cfg     <= w_cfg_in;
                    r_cfg_err <= w_cfg_err_in;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_accept && w_eof) begin
                        r_frame_done <= 1'b1;
                        r_state      <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handshake and keep test
    // ------------------------------------------------------------------
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  w_in_ready;
    logic                  w_keep;
    logic                  w_last;
    logic [c_cw-1:0]       w_col_ext;
    logic [c_cw-1:0]       w_row_ext;
    logic [c_cw-1:0]       w_x_lo;
    logic [c_cw-1:0]       w_x_hi;
    logic [c_cw-1:0]       w_y_lo;
    logic [c_cw-1:0]       w_y_hi;

    // Dropped pixels obey the same ready rule as kept ones, so the input
    // side never needs to know in advance whether a pixel will be kept.
    assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    assign w_col_ext  = c_cw'(w_col);
    assign w_row_ext  = c_cw'(w_row);
    assign w_x_lo     = c_cw'(r_cfg.x0);
    assign w_y_lo     = c_cw'(r_cfg.y0);
    assign w_x_hi     = c_cw'(r_cfg.x0) + c_cw'(r_cfg.w);
    assign w_y_hi     = c_cw'(r_cfg.y0) + c_cw'(r_cfg.h);

    assign w_keep = !r_cfg_err &&
                    (w_col_ext >= w_x_lo) && (w_col_ext < w_x_hi) &&
                    (w_row_ext >= w_y_lo) && (w_row_ext < w_y_hi);

    // Bottom-right corner of the window, written as pos+1 == lo+extent so
    // no subtraction (and no underflow) is needed.
    assign w_last = ((w_col_ext + c_cw'(1)) == w_x_hi) &&
                    ((w_row_ext + c_cw'(1)) == w_y_hi);

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept && w_keep) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_last;
            r_out_data  <= in_data;
        end else if (out_ready) begin
            // Data is left as-is; only the qualifiers are retired.
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;
    assign cfg_err    = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_crop_window_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crop_window_stage
//  Description : Self-checking bench for crop_window_stage. Drives frames of
//                random pixel words, optionally with idle gaps, under several
//                downstream ready patterns, and compares the cropped stream
//                against a reference computed from the crop rectangle rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crop_window_stage;

    localparam int DW = 32;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int XW = 4;
    localparam int YW = 3;

    typedef struct {
        int x0;
        int y0;
        int w;
        int h;
    } tcfg_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [XW-1:0] cfg_x0 = '0;
    logic [YW-1:0] cfg_y0 = '0;
    logic [XW-1:0] cfg_w = '0;
    logic [YW-1:0] cfg_h = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          frame_done;
    logic          cfg_err;

    crop_window_stage #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_x0     (cfg_x0),
        .cfg_y0     (cfg_y0),
        .cfg_w      (cfg_w),
        .cfg_h      (cfg_h),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_fd_seen = 0;
    int          n_fd_expected = 0;
    int          ready_mode = 0;
    bit          rst_seen = 1'b0;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    // ---------------- reference rules ----------------
    function automatic bit cfg_bad(input tcfg_t c);
        return (c.w == 0) || (c.h == 0) || (c.x0 + c.w > IW) || (c.y0 + c.h > IH);
    endfunction

    function automatic bit in_window(input tcfg_t c, input int col, input int row);
        return !cfg_bad(c) && col >= c.x0 && col < c.x0 + c.w &&
               row >= c.y0 && row < c.y0 + c.h;
    endfunction

    task automatic set_cfg(input tcfg_t c);
        logic [31:0] v;
        v = c.x0; cfg_x0 = v[XW-1:0];
        v = c.y0; cfg_y0 = v[YW-1:0];
        v = c.w;  cfg_w  = v[XW-1:0];
        v = c.h;  cfg_h  = v[YW-1:0];
    endtask

    // ---------------- output side: ready pattern, scoreboard, protocol ----
    initial begin
        int          phase;
        bit          prev_stall;
        logic [DW-1:0] prev_data;
        logic        prev_last;
        logic [32:0] e;
        phase = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (phase % 4 == 0) || (phase % 4 == 3);
                    phase++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #4;
            if (rst_seen) begin
                prev_stall = 1'b0;
                rst_seen = 1'b0;
            end
            if (!reset) begin
                if (frame_done) n_fd_seen++;
                if (prev_stall) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_data", 64'(out_data), 64'(prev_data));
                    check("stall_last", 64'(out_last), 64'(prev_last));
                end
                if (out_valid && !out_ready) check("in_ready_when_stalled", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    check("expected_word_available", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_word", {31'd0, out_last, out_data}, {31'd0, e});
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    // ---------------- input side: one frame ----------------
    // Drives pixels in raster order. 'nxt' is put on the cfg ports after
    // 'change_at' accepts (-1: never); 'abort_after' stops early (-1: never).
    task automatic run_frame(input tcfg_t cur, input tcfg_t nxt, input int change_at,
                             input int abort_after, input bit gaps);
        int          acc;
        int          waited;
        int          col;
        int          row;
        logic [DW-1:0] d;
        acc = 0;
        for (int p = 0; p < IW * IH; p++) begin
            if (acc == abort_after) break;
            col = p % IW;
            row = p / IW;
            d = $urandom;
            @(negedge clk);
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = d;
            waited = 0;
            #4;
            while (!in_ready) begin
                waited++;
                if (waited > 200) begin
                    check("accept_timeout", 64'(in_ready), 64'd1);
                    finish_sim();
                end
                @(negedge clk);
                #4;
            end
            if (p == 0) check("cfg_err", 64'(cfg_err), 64'(cfg_bad(cur)));
            if (in_window(cur, col, row))
                exp_q.push_back({(col == cur.x0 + cur.w - 1) && (row == cur.y0 + cur.h - 1), d});
            acc++;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (acc == change_at) set_cfg(nxt);
            if (p == IW * IH - 1) begin
                check("frame_done_pulse", 64'(frame_done), 64'd1);
                check("in_ready_in_load", 64'(in_ready), 64'd0);
                n_fd_expected++;
            end
        end
    endtask

    task automatic frame(input tcfg_t c, input int mode, input bit gaps);
        ready_mode = mode;
        set_cfg(c);
        run_frame(c, c, -1, -1, gaps);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        tcfg_t c_basic;
        tcfg_t c_full;
        tcfg_t c_w0;
        tcfg_t c_ovf;
        tcfg_t c_col0;
        tcfg_t c_rnd;
        int    waited;
        c_basic = '{2, 1, 3, 2};
        c_full  = '{0, 0, 8, 6};
        c_w0    = '{2, 1, 0, 2};
        c_ovf   = '{6, 1, 3, 2};
        c_col0  = '{0, 0, 1, 2};

        set_cfg(c_basic);
        #2;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_last", 64'(out_last), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        check("reset_cfg_err", 64'(cfg_err), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        frame(c_basic, 0, 1'b0);
        frame(c_basic, 1, 1'b0);
        frame(c_full, 2, 1'b1);
        frame(c_w0, 0, 1'b0);
        frame(c_ovf, 2, 1'b1);
        frame(c_basic, 0, 1'b0);

        // Config changed mid-frame only takes effect on the next frame.
        ready_mode = 1;
        set_cfg(c_basic);
        run_frame(c_basic, c_col0, 20, -1, 1'b0);
        frame(c_col0, 0, 1'b0);

        // Asynchronous reset while a kept word is waiting on the output.
        ready_mode = 0;
        set_cfg(c_basic);
        run_frame(c_basic, c_basic, -1, 13, 1'b0);
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_out_last", 64'(out_last), 64'd0);
        exp_q.delete();
        rst_seen = 1'b1;
        #1;
        reset = 1'b0;
        frame(c_basic, 1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            c_rnd.x0 = $urandom_range(0, IW);
            c_rnd.y0 = $urandom_range(0, IH);
            c_rnd.w  = $urandom_range(0, IW);
            c_rnd.h  = $urandom_range(0, IH);
            frame(c_rnd, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        ready_mode = 0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (4) @(negedge clk);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("frame_done_count", 64'(n_fd_seen), 64'(n_fd_expected));
        check("final_out_valid", 64'(out_valid), 64'd0);
        finish_sim();
    end

endmodule
`default_nettype wire
